sram_fill_unit: RTL and testbench

- Line-fill stage directly upstream of the cache data SRAM.
- Accepts a fill request (target row plus critical-word index), then collects WIDTH/WORD_SIZE beats from the memory bus in wrapping order.
- Issues the assembled line to the SRAM write port as one full-mask write.
- Provides the SRAM writeAddr/writeData/writeEnable signals directly.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_fill_unit.sv | 161 ++++++++++++++++
 tb/tb_sram_fill_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared defaults and FSM state type for the SRAM line-fill path.
package sram_pkg;

    localparam int WIDTH        = 512;
    localparam int LOG_NUM_ROWS = 9;
    localparam int WORD_SIZE    = 64;
    localparam int BEATS        = WIDTH / WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/sram_fill_unit.sv
// Line-fill stage: collects wrapped memory beats and issues one full-mask SRAM row write.
// Write lands the cycle after the last beat; no beat backpressure. Optional macro: SRAM_FILL_CRIT_FWD_EN.
module sram_fill_unit
    import sram_pkg::*;
#(
    parameter  int WIDTH        = sram_pkg::WIDTH,
    parameter  int LOG_NUM_ROWS = sram_pkg::LOG_NUM_ROWS,
    parameter  int WORD_SIZE    = sram_pkg::WORD_SIZE,
    localparam int BEATS        = WIDTH / WORD_SIZE,
    localparam int LOG_BEATS    = $clog2(BEATS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [LOG_NUM_ROWS-1:0] req_row,
    input  logic [LOG_BEATS-1:0]    req_first_word,
    input  logic                    beat_valid,
    input  logic [WORD_SIZE-1:0]    beat_data,
    output logic [LOG_NUM_ROWS-1:0] sram_writeAddr,
    output logic [WIDTH-1:0]        sram_writeData,
    output logic [BEATS-1:0]        sram_writeEnable,
    output logic                    fill_done,
    output logic                    crit_valid,
    output logic [WORD_SIZE-1:0]    crit_data,
    output logic                    proto_err
);

    localparam logic [LOG_BEATS-1:0] LAST = LOG_BEATS'(BEATS - 1);

    fill_state_t               state_q, state_d;
    logic [LOG_NUM_ROWS-1:0]   row_q, row_d;
    logic [LOG_BEATS-1:0]      idx_q, idx_d;
    logic [LOG_BEATS-1:0]      cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]      line_q [BEATS];
    logic [WORD_SIZE-1:0]      line_d [BEATS];
    logic [LOG_NUM_ROWS-1:0]   wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]          wr_data_q, wr_data_d;
    logic [BEATS-1:0]          wr_en_q, wr_en_d;
    logic                      fill_done_q, fill_done_d;
    logic                      proto_err_q, proto_err_d;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = '0;
        fill_done_d = 1'b0;
        proto_err_d = proto_err_q;

        case (state_q)
            IDLE: begin
                if (beat_valid) begin
                    proto_err_d = 1'b1;
                end
                if (req_valid) begin
                    row_d   = req_row;
                    idx_d   = req_first_word;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (beat_valid) begin
                    line_d[idx_q] = beat_data;
                    idx_d = (idx_q == LAST) ? '0 : idx_q + LOG_BEATS'(1);
                    cnt_d = cnt_q + LOG_BEATS'(1);
                    if (cnt_q == LAST) begin
                        // Final beat bypasses the buffer so the write can issue next cycle.
                        for (int i = 0; i < BEATS; i++) begin
                            wr_data_d[i*WORD_SIZE +: WORD_SIZE] =
                                (LOG_BEATS'(i) == idx_q) ? beat_data : line_q[i];
                        end
                        wr_en_d     = '1;
                        wr_addr_d   = row_q;
                        fill_done_d = 1'b1;
                        state_d     = WRITE;
                    end
                end
            end
            WRITE: begin
                if (beat_valid) begin
                    proto_err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= '0;
            fill_done_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            fill_done_q <= fill_done_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Line storage needs no reset: every slot is rewritten before a fill can complete.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    assign req_ready        = (state_q == IDLE);
    assign sram_writeAddr   = wr_addr_q;
    assign sram_writeData   = wr_data_q;
    assign sram_writeEnable = wr_en_q;
    assign fill_done        = fill_done_q;
    assign proto_err        = proto_err_q;

`ifdef SRAM_FILL_CRIT_FWD_EN
    logic                 crit_valid_q, crit_valid_d;
    logic [WORD_SIZE-1:0] crit_data_q, crit_data_d;

    always_comb begin
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        if (state_q == FILL && beat_valid && cnt_q == '0) begin
            crit_valid_d = 1'b1;
            crit_data_d  = beat_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
        end
    end

    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_sram_fill_unit.sv
// Directed bench for sram_fill_unit with hand-built expected lines.
module tb_sram_fill_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [8:0]   req_row;
    logic [2:0]   req_first_word;
    logic         beat_valid;
    logic [63:0]  beat_data;
    logic [8:0]   sram_writeAddr;
    logic [511:0] sram_writeData;
    logic [7:0]   sram_writeEnable;
    logic         fill_done;
    logic         crit_valid;
    logic [63:0]  crit_data;
    logic         proto_err;

    int checks = 0;
    int errors = 0;

`ifdef SRAM_FILL_CRIT_FWD_EN
    localparam bit CRIT_EN = 1'b1;
`else
    localparam bit CRIT_EN = 1'b0;
`endif

    sram_fill_unit dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_row          (req_row),
        .req_first_word   (req_first_word),
        .beat_valid       (beat_valid),
        .beat_data        (beat_data),
        .sram_writeAddr   (sram_writeAddr),
        .sram_writeData   (sram_writeData),
        .sram_writeEnable (sram_writeEnable),
        .fill_done        (fill_done),
        .crit_valid       (crit_valid),
        .crit_data        (crit_data),
        .proto_err        (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 512'(req_ready), 512'(1));
        check({tag, "_wen"}, 512'(sram_writeEnable), 512'(0));
        check({tag, "_waddr"}, 512'(sram_writeAddr), 512'(0));
        check({tag, "_wdata"}, sram_writeData, 512'(0));
        check({tag, "_fill_done"}, 512'(fill_done), 512'(0));
        check({tag, "_crit_valid"}, 512'(crit_valid), 512'(0));
        check({tag, "_crit_data"}, 512'(crit_data), 512'(0));
        check({tag, "_proto_err"}, 512'(proto_err), 512'(0));
    endtask

    // Present a request for one cycle; if hold is set, req_valid stays high afterwards.
    task automatic start_req(input [8:0] row, input [2:0] first, input bit hold);
        req_valid      = 1'b1;
        req_row        = row;
        req_first_word = first;
        tick();
        if (!hold) req_valid = 1'b0;
        check("req_ready_in_fill", 512'(req_ready), 512'(0));
    endtask

    // Eight beats base+k, optional 3-cycle gap after beat gap_at, then write checks.
    task automatic run_beats(input string tag, input [8:0] row, input [2:0] first,
                             input [63:0] base, input int gap_at, input bit exp_perr);
        logic [511:0] exp_line;
        exp_line = '0;
        for (int k = 0; k < 8; k++) begin
            exp_line[((int'(first) + k) % 8) * 64 +: 64] = base + 64'(k);
        end
        for (int k = 0; k < 8; k++) begin
            beat_valid = 1'b1;
            beat_data  = base + 64'(k);
            tick();
            beat_valid = 1'b0;
            beat_data  = '0;
            if (k == 0) begin
                check({tag, "_crit_valid"}, 512'(crit_valid), 512'(CRIT_EN));
                if (CRIT_EN) check({tag, "_crit_data"}, 512'(crit_data), 512'(base));
            end
            if (k == 1) check({tag, "_crit_pulse"}, 512'(crit_valid), 512'(0));
            if (k < 7) begin
                check({tag, "_wen_early"}, 512'(sram_writeEnable), 512'(0));
                check({tag, "_done_early"}, 512'(fill_done), 512'(0));
            end
            if (k == gap_at) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    check({tag, "_wen_gap"}, 512'(sram_writeEnable), 512'(0));
                    check({tag, "_req_ready_gap"}, 512'(req_ready), 512'(0));
                end
            end
        end
        check({tag, "_wen"}, 512'(sram_writeEnable), 512'(8'hFF));
        check({tag, "_waddr"}, 512'(sram_writeAddr), 512'(row));
        check({tag, "_wdata"}, sram_writeData, exp_line);
        check({tag, "_fill_done"}, 512'(fill_done), 512'(1));
        check({tag, "_req_ready_write"}, 512'(req_ready), 512'(0));
        tick();
        check({tag, "_req_ready_after"}, 512'(req_ready), 512'(1));
        check({tag, "_wen_after"}, 512'(sram_writeEnable), 512'(0));
        check({tag, "_done_after"}, 512'(fill_done), 512'(0));
        check({tag, "_wdata_hold"}, sram_writeData, exp_line);
        check({tag, "_waddr_hold"}, 512'(sram_writeAddr), 512'(row));
        check({tag, "_proto_err"}, 512'(proto_err), 512'(exp_perr));
    endtask

    initial begin
        reset          = 1'b1;
        req_valid      = 1'b0;
        req_row        = '0;
        req_first_word = '0;
        beat_valid     = 1'b0;
        beat_data      = '0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("reset");
        tick();
        check("idle_req_ready", 512'(req_ready), 512'(1));

        // Aligned fill
        start_req(9'h05A, 3'd0, 1'b0);
        run_beats("aligned", 9'h05A, 3'd0, 64'h0, -1, 1'b0);

        // Wrapped fill starting at slot 5
        start_req(9'h011, 3'd5, 1'b0);
        run_beats("wrapped", 9'h011, 3'd5, 64'hA0, -1, 1'b0);

        // Gap of three idle cycles between beats 3 and 4
        start_req(9'h1F3, 3'd2, 1'b0);
        run_beats("gapped", 9'h1F3, 3'd2, 64'hDEAD_0000_0000_0010, 3, 1'b0);

        // Back-to-back: req_valid stays high; row 2 must not be taken until after the write
        start_req(9'd1, 3'd0, 1'b1);
        req_row        = 9'd2;
        req_first_word = 3'd6;
        run_beats("b2b_row1", 9'd1, 3'd0, 64'h1000, -1, 1'b0);
        start_req(9'd2, 3'd6, 1'b0);
        run_beats("b2b_row2", 9'd2, 3'd6, 64'h2000, -1, 1'b0);

        // Stray beat while idle
        beat_valid = 1'b1;
        beat_data  = 64'hBAD;
        tick();
        beat_valid = 1'b0;
        check("stray_proto_err", 512'(proto_err), 512'(1));
        check("stray_wen", 512'(sram_writeEnable), 512'(0));
        check("stray_req_ready", 512'(req_ready), 512'(1));
        tick();
        check("stray_sticky", 512'(proto_err), 512'(1));
        start_req(9'h0C3, 3'd7, 1'b0);
        run_beats("after_stray", 9'h0C3, 3'd7, 64'h5500, -1, 1'b1);

        // Reset after the fourth beat discards the partial line
        start_req(9'h033, 3'd1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            beat_valid = 1'b1;
            beat_data  = 64'h7700 + 64'(k);
            tick();
        end
        beat_valid = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("mid_reset");
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_reset_no_write", 512'(sram_writeEnable), 512'(0));
        end
        start_req(9'h144, 3'd3, 1'b0);
        run_beats("post_reset", 9'h144, 3'd3, 64'h8800, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
